nand_page_buffer: RTL and testbench
===================================

Name: nand_page_buffer

Overview:
- Ping-pong page buffer directly upstream of the NAND page-write FSM.
- Host side streams bytes in with a valid/ready handshake and fills one 2048-byte bank while the write FSM drains the other bank by random-access index.
- Asserts buffer_ready when a complete page is available.
- The write FSM pulses page_release (driven from its WriteDone) to free the bank.

Parameters:
- PAGE_BYTES, 2048, bytes per page (one bank); power of two.
- ADDR_W, 11, index width; must equal log2(PAGE_BYTES).

Ports:
- clk200 input 1: clock, all logic on posedge.
- reset input 1: asynchronous, active-high.
- host_valid input 1: host byte valid.
- host_data input 8: host byte.
- host_ready output 1: buffer accepts a byte this cycle.
- page_abort input 1: discard the partially filled bank.
- buffer_ready output 1: read bank holds a complete page.
- rd_addr input ADDR_W: byte index into the read bank.
- rd_data output 8: registered data at rd_addr.
- page_release input 1: one-cycle pulse; read bank consumed.
- fill_count output ADDR_W+1: bytes written into the current fill bank.
- pages_pending output 2: number of full banks (0..2).

Behaviour:
- Storage: 2 x PAGE_BYTES x 8 array, single clock. Bank state bits full[1:0]; pointers wr_bank, rd_bank, wr_ptr[ADDR_W:0].
- Reset values: full=00, wr_bank=0, rd_bank=0, wr_ptr=0, host_ready=0 during reset, buffer_ready=0, rd_data=0, fill_count=0, pages_pending=0.
- Fill FSM states: F_FILL, F_STALL.
  - F_FILL: host_ready=1. A transfer occurs when host_valid & host_ready: write host_data to mem[wr_bank][wr_ptr], then wr_ptr++.
  - On the transfer with wr_ptr==PAGE_BYTES-1:
    - set full[wr_bank];
    - toggle wr_bank;
    - wr_ptr=0;
    - if full[new wr_bank] is set, go to F_STALL.
  - F_STALL: host_ready=0. Return to F_FILL the cycle after full[wr_bank] clears.
- Read side:
  - buffer_ready = full[rd_bank], registered, so it rises 1 cycle after the setting transfer.
  - rd_data = mem[rd_bank][rd_addr], with 1-cycle read latency; valid regardless of buffer_ready. The consumer must only trust it while buffer_ready=1.
  - page_release while buffer_ready=1: clear full[rd_bank], toggle rd_bank. buffer_ready drops the next cycle and rises again the following cycle if the other bank is already full.
  - page_release while buffer_ready=0: ignored, no state change.
- page_abort: wr_ptr=0 and the fill-bank content is discarded. Full banks are unaffected. Abort has priority over a same-cycle host transfer (byte dropped). Ignored in F_STALL.
- Simultaneous last-byte fill and page_release on the other bank: both take effect. If the release frees the bank just toggled to, go directly to F_FILL with no stall cycle.
- pages_pending = full[0]+full[1]. fill_count = wr_ptr.
- Reset mid-operation: all pages are lost and outputs return to reset values asynchronously. Memory content is not cleared.
- Wrap: wr_ptr never exceeds PAGE_BYTES; wr_bank and rd_bank are 1-bit and wrap naturally.

Optional Feature:
- Macro NAND_PAGE_BUF_XSUM_EN.
- When defined:
  - adds output page_xsum[7:0]: the running XOR of all bytes of each page, stored per bank when the page completes.
  - page_xsum shows the value for rd_bank, valid while buffer_ready=1, and resets to 0.
  - page_abort clears the running XOR.
- When undefined: no port, no logic; the rest of the behaviour is identical.

Test Plan:
- Reset, then stream 2048 bytes of value (i & 0xFF) with host_valid held high. Required response:
  - host_ready=1 throughout;
  - buffer_ready rises 1 cycle after the 2048th transfer;
  - pages_pending=1;
  - rd_addr=5 gives rd_data=0x05 one cycle later, and rd_addr=2047 gives 0xFF.
- Fill two pages without release. Required response:
  - host_ready=0 after the 4096th byte;
  - pages_pending=2;
  - page_release pulse frees a bank: buffer_ready drops for one cycle, then rises; host_ready returns to 1.
- Write 100 bytes, assert page_abort with host_valid=1 in the same cycle. Required response:
  - fill_count=0;
  - byte dropped;
  - the next 2048 bytes form the page starting at index 0;
  - buffer_ready=0 until then.
- page_release pulse while buffer_ready=0. Required response:
  - no change to rd_bank or pages_pending;
  - the following full page reads back correctly.
- Last byte of page 2 in the same cycle as page_release of page 1. Required response:
  - pages_pending stays 1;
  - host_ready never drops;
  - buffer_ready deasserts for exactly one cycle.
- With NAND_PAGE_BUF_XSUM_EN, fill a page with bytes 0x01..(wrapping i&0xFF)+1. Required response:
  - page_xsum equals the XOR computed by the bench model while buffer_ready=1;
  - reset mid-fill leaves page_xsum=0.

Source files
------------

// File: rtl/nand_page_buffer.sv
// Ping-pong page buffer feeding the NAND page-write FSM: host fills one bank while the FSM drains the other.
// Optional NAND_PAGE_BUF_XSUM_EN adds page_xsum, the XOR of all bytes of the page in the read bank.
module nand_page_buffer #(
  parameter int PAGE_BYTES = 2048,
  parameter int ADDR_W     = 11
) (
  input  logic              clk200,
  input  logic              reset,
  input  logic              host_valid,
  input  logic [7:0]        host_data,
  output logic              host_ready,
  input  logic              page_abort,
  output logic              buffer_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  input  logic              page_release,
  output logic [ADDR_W:0]   fill_count,
  output logic [1:0]        pages_pending
`ifdef NAND_PAGE_BUF_XSUM_EN
  ,
  output logic [7:0]        page_xsum
`endif
);

  typedef enum logic {F_FILL, F_STALL} fill_state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(PAGE_BYTES - 1);
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  logic [7:0]      mem [0:2*PAGE_BYTES-1];
  fill_state_t     state, state_next;
  logic [1:0]      full, full_next;
  logic            wr_bank, wr_bank_next;
  logic            rd_bank, rd_bank_next;
  logic [ADDR_W:0] wr_ptr, wr_ptr_next;
  logic            xfer, last_xfer, release_ok;

  // Abort wins over a same-cycle byte, so the byte is never written.
  assign host_ready = (state == F_FILL) & ~reset;
  assign xfer       = host_valid & host_ready & ~page_abort;
  assign last_xfer  = xfer & (wr_ptr == LAST_IDX);
  assign release_ok = page_release & buffer_ready;

  always_comb begin
    state_next   = state;
    full_next    = full;
    wr_bank_next = wr_bank;
    rd_bank_next = rd_bank;
    wr_ptr_next  = wr_ptr;
    if (release_ok) begin
      full_next[rd_bank] = 1'b0;
      rd_bank_next       = ~rd_bank;
    end
    case (state)
      F_FILL: begin
        if (page_abort) begin
          wr_ptr_next = '0;
        end else if (last_xfer) begin
          full_next[wr_bank] = 1'b1;
          wr_bank_next       = ~wr_bank;
          wr_ptr_next        = '0;
          // A release landing in the same cycle may already have freed the next bank.
          if (full_next[wr_bank_next]) state_next = F_STALL;
        end else if (xfer) begin
          wr_ptr_next = wr_ptr + PTR_ONE;
        end
      end
      F_STALL: begin
        if (!full[wr_bank]) state_next = F_FILL;
      end
      default: state_next = F_FILL;
    endcase
  end

  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      state        <= F_FILL;
      full         <= '0;
      wr_bank      <= 1'b0;
      rd_bank      <= 1'b0;
      wr_ptr       <= '0;
      buffer_ready <= 1'b0;
    end else begin
      state        <= state_next;
      full         <= full_next;
      wr_bank      <= wr_bank_next;
      rd_bank      <= rd_bank_next;
      wr_ptr       <= wr_ptr_next;
      buffer_ready <= release_ok ? 1'b0 : full[rd_bank];
    end
  end

  always_ff @(posedge clk200) begin
    if (xfer) mem[{wr_bank, wr_ptr[ADDR_W-1:0]}] <= host_data;
  end

  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[{rd_bank, rd_addr}];
  end

  assign fill_count    = wr_ptr;
  assign pages_pending = {1'b0, full[0]} + {1'b0, full[1]};

`ifdef NAND_PAGE_BUF_XSUM_EN
  logic [7:0] run_xsum;
  logic [7:0] bank_xsum [0:1];

  always_ff @(posedge clk200 or posedge reset) begin
    if (reset) begin
      run_xsum     <= '0;
      bank_xsum[0] <= '0;
      bank_xsum[1] <= '0;
    end else if (state == F_FILL && page_abort) begin
      run_xsum <= '0;
    end else if (last_xfer) begin
      bank_xsum[wr_bank] <= run_xsum ^ host_data;
      run_xsum           <= '0;
    end else if (xfer) begin
      run_xsum <= run_xsum ^ host_data;
    end
  end

  assign page_xsum = bank_xsum[rd_bank];
`endif

endmodule

// File: tb/tb_nand_page_buffer.sv
// Scoreboard bench for nand_page_buffer: stimulus queues expected outputs, a negedge monitor checks them.
// Build with NAND_PAGE_BUF_XSUM_EN defined to also exercise page_xsum.
module tb_nand_page_buffer;

  localparam int PAGE_BYTES = 2048;
  localparam int ADDR_W     = 11;
  localparam int SEL_HR = 0, SEL_BR = 1, SEL_PP = 2, SEL_FC = 3, SEL_RD = 4, SEL_XS = 5;

  logic              clk200 = 1'b0;
  logic              reset;
  logic              host_valid;
  logic [7:0]        host_data;
  logic              host_ready;
  logic              page_abort;
  logic              buffer_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              page_release;
  logic [ADDR_W:0]   fill_count;
  logic [1:0]        pages_pending;
`ifdef NAND_PAGE_BUF_XSUM_EN
  logic [7:0]        page_xsum;
`endif

  typedef struct {
    int at;
    int sel;
    int exp;
  } item_t;

  item_t sb[$];
  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  nand_page_buffer #(.PAGE_BYTES(PAGE_BYTES), .ADDR_W(ADDR_W)) dut (
    .clk200        (clk200),
    .reset         (reset),
    .host_valid    (host_valid),
    .host_data     (host_data),
    .host_ready    (host_ready),
    .page_abort    (page_abort),
    .buffer_ready  (buffer_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .page_release  (page_release),
    .fill_count    (fill_count),
    .pages_pending (pages_pending)
`ifdef NAND_PAGE_BUF_XSUM_EN
    ,
    .page_xsum     (page_xsum)
`endif
  );

  always #5 clk200 = ~clk200;

  always @(posedge clk200) cyc <= cyc + 1;

  function automatic logic [7:0] patByte(input int pat, input int i);
    case (pat)
      0:       return 8'(i);
      1:       return 8'(3 * i + 7);
      2:       return 8'(i ^ 'h5A);
      3:       return 8'(255 - i);
      4:       return 8'(i + 1);
      default: return (i < 5) ? 8'(i * 17) : 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] pageXor(input int pat);
    logic [7:0] x = 8'h00;
    for (int i = 0; i < PAGE_BYTES; i++) x = x ^ patByte(pat, i);
    return x;
  endfunction

  function automatic string selName(input int sel);
    case (sel)
      SEL_HR:  return "host_ready";
      SEL_BR:  return "buffer_ready";
      SEL_PP:  return "pages_pending";
      SEL_FC:  return "fill_count";
      SEL_RD:  return "rd_data";
      default: return "page_xsum";
    endcase
  endfunction

  function automatic int getVal(input int sel);
    case (sel)
      SEL_HR:  return int'(host_ready);
      SEL_BR:  return int'(buffer_ready);
      SEL_PP:  return int'(pages_pending);
      SEL_FC:  return int'(fill_count);
      SEL_RD:  return int'(rd_data);
`ifdef NAND_PAGE_BUF_XSUM_EN
      SEL_XS:  return int'(page_xsum);
`endif
      default: return -1;
    endcase
  endfunction

  task automatic checkOutput(input item_t it);
    int act;
    act = getVal(it.sel);
    total++;
    if (act != it.exp) begin
      bad++;
      $display("[TB] FAIL %s cyc=%0d got=0x%0h expected=0x%0h", selName(it.sel), cyc, act, it.exp);
    end
  endtask

  // Monitor: compare every queued expectation that has come due, away from the active edge.
  always @(negedge clk200) begin
    item_t it;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      it = sb.pop_front();
      checkOutput(it);
    end
  end

  task automatic tick();
    @(posedge clk200);
    #1;
  endtask

  task automatic expectNow(input int sel, input int exp);
    sb.push_back('{cyc, sel, exp});
  endtask

  task automatic expectNext(input int sel, input int exp);
    sb.push_back('{cyc + 1, sel, exp});
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ab, input logic rel);
    host_valid   = v;
    host_data    = d;
    page_abort   = ab;
    page_release = rel;
  endtask

  task automatic sendPage(input int pat, input bit rel_at_last, input int br_mid);
    for (int i = 0; i < PAGE_BYTES; i++) begin
      applyStimulus(1'b1, patByte(pat, i), 1'b0, rel_at_last && (i == PAGE_BYTES - 1));
      expectNow(SEL_HR, 1);
      if (i == 100) expectNow(SEL_FC, 100);
      if (i == 1000) expectNow(SEL_BR, br_mid);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic readAt(input int addr, input int exp);
    rd_addr = ADDR_W'(addr);
    expectNext(SEL_RD, exp);
    tick();
  endtask

  task automatic pulseRelease();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    expectNow(SEL_HR, 0);
    expectNow(SEL_BR, 0);
    expectNow(SEL_PP, 0);
    expectNow(SEL_FC, 0);
    expectNow(SEL_RD, 0);
    tick();
    reset = 1'b0;
    expectNow(SEL_HR, 1);
    tick();

    // First page (i & 0xFF) into bank 0.
    sendPage(0, 1'b0, 0);
    expectNow(SEL_PP, 1);
    expectNow(SEL_FC, 0);
    expectNow(SEL_BR, 0);
    tick();
    expectNow(SEL_BR, 1);
    readAt(5, 8'h05);
    readAt(2047, 8'hFF);
    readAt(0, 8'h00);

    // Second page fills bank 1; the buffer then stalls the host.
    sendPage(1, 1'b0, 1);
    expectNow(SEL_HR, 0);
    expectNow(SEL_PP, 2);
    expectNow(SEL_BR, 1);
    expectNow(SEL_FC, 0);
    applyStimulus(1'b1, 8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      expectNow(SEL_HR, 0);
      tick();
    end
    expectNow(SEL_FC, 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    readAt(7, 8'h07);
    pulseRelease();
    expectNow(SEL_BR, 0);
    expectNow(SEL_PP, 1);
    expectNow(SEL_HR, 0);
    tick();
    expectNow(SEL_BR, 1);
    expectNow(SEL_HR, 1);
    readAt(0, 8'h07);
    readAt(10, 8'h25);
    readAt(2047, 8'h04);

    // Drain bank 1, then a release with nothing ready must be ignored.
    pulseRelease();
    expectNow(SEL_BR, 0);
    expectNow(SEL_PP, 0);
    tick();
    expectNow(SEL_BR, 0);
    pulseRelease();
    expectNow(SEL_BR, 0);
    expectNow(SEL_PP, 0);
    tick();
    expectNow(SEL_BR, 0);
    expectNow(SEL_PP, 0);

    // 100 bytes, then abort with a byte offered in the same cycle.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
      tick();
    end
    expectNow(SEL_FC, 100);
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    expectNow(SEL_FC, 0);
    expectNow(SEL_BR, 0);
    sendPage(2, 1'b0, 0);
    expectNow(SEL_PP, 1);
    expectNow(SEL_BR, 0);
    tick();
    expectNow(SEL_BR, 1);
    readAt(0, 8'h5A);
    readAt(99, 8'h39);
    readAt(100, 8'h3E);
    readAt(2047, 8'hA5);

    // Last byte of the next page coincides with releasing the ready page.
    sendPage(3, 1'b1, 1);
    expectNow(SEL_PP, 1);
    expectNow(SEL_HR, 1);
    expectNow(SEL_BR, 0);
    tick();
    expectNow(SEL_BR, 1);
    expectNow(SEL_HR, 1);
    expectNow(SEL_PP, 1);
    readAt(0, 8'hFF);
    readAt(1, 8'hFE);
    readAt(2047, 8'h00);

`ifdef NAND_PAGE_BUF_XSUM_EN
    expectNow(SEL_XS, int'(pageXor(3)));
    // Bytes before an abort must not leak into the next page's checksum.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    tick();
    pulseRelease();
    expectNow(SEL_PP, 0);
    sendPage(5, 1'b0, 0);
    tick();
    expectNow(SEL_BR, 1);
    expectNow(SEL_XS, int'(pageXor(5)));
    expectNow(SEL_XS, 8'h44);
    pulseRelease();
    sendPage(4, 1'b0, 0);
    tick();
    expectNow(SEL_BR, 1);
    expectNow(SEL_XS, int'(pageXor(4)));
`endif

    // Reset in the middle of a fill.
    for (int i = 0; i < 50; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    expectNow(SEL_FC, 50);
    tick();
    reset = 1'b1;
    #1;
    expectNow(SEL_HR, 0);
    expectNow(SEL_BR, 0);
    expectNow(SEL_PP, 0);
    expectNow(SEL_FC, 0);
    expectNow(SEL_RD, 0);
`ifdef NAND_PAGE_BUF_XSUM_EN
    expectNow(SEL_XS, 0);
`endif
    tick();
    reset = 1'b0;
    expectNow(SEL_HR, 1);
    expectNow(SEL_FC, 0);
    tick();

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL %s never checked expected=0x%0h", selName(it.sel), it.exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
